reservoir_core_param: RTL and testbench

//  Parametrised delay-loop reservoir core: ring of NUM_VIRTUAL_NODES virtual nodes of NODE_DATA_WIDTH bits.

---
 rtl/reservoir_core_param_if.sv | 20 ++
 rtl/reservoir_core_param.sv | 159 +++++++++++++++
 tb/tb_reservoir_core_param.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reservoir_core_param_if.sv
// Start/done handshake between the reservoir core
// and its pluggable nonlinear-function backend.
interface reservoir_core_param_if #(
  parameter int W = 12
);
  logic         nl_start;
  logic [W-1:0] nl_din;
  logic         nl_done;
  logic [W-1:0] nl_dout;

  modport master (
    output nl_start, nl_din,
    input  nl_done, nl_dout
  );

  modport slave (
    input  nl_start, nl_din,
    output nl_done, nl_dout
  );
endinterface

// File: rtl/reservoir_core_param.sv
// Delay-loop reservoir: ring of virtual nodes fed by
// saturated input+feedback through a nonlinear unit.
module reservoir_core_param #(
  parameter int NUM_VIRTUAL_NODES = 10,
  parameter int NODE_DATA_WIDTH   = 12,
  parameter int DATA_WIDTH        = 32,
  parameter int FEEDBACK_SHIFT    = 2,
  parameter int MEM_WAIT_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES    = 1024,
  localparam int SEL_W = $clog2(NUM_VIRTUAL_NODES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       reservoir_valid,
  input  logic                       load_node,
  input  logic [NODE_DATA_WIDTH-1:0] load_node_din,
  input  logic [SEL_W-1:0]           node_sel,
  output logic [NODE_DATA_WIDTH-1:0] node_dout,
  reservoir_core_param_if.master     nl,
  output logic                       frame_done,
  output logic                       sat_err,
  output logic                       timeout_err
);

  localparam int N   = NUM_VIRTUAL_NODES;
  localparam int W   = NODE_DATA_WIDTH;
  localparam int SW  = DATA_WIDTH + 1;
  localparam int CM  = (MEM_WAIT_CYCLES > TIMEOUT_CYCLES) ?
                       MEM_WAIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW  = $clog2(CM + 1);
  localparam int FCW = $clog2(N);

  localparam logic [SW-1:0] SAT_MAX =
    {{(SW-W){1'b0}}, {W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    NL_REQ,
    NL_WAIT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [FCW-1:0]  upd_cnt;
  logic [W-1:0]    nodes [N];
  logic [W-1:0]    nl_din_q;

  logic [SW-1:0]   sum;
  logic            sat;
  logic [W-1:0]    sum_sat;
  logic            wait_last;
  logic            to_last;
  logic            done_hit;
  logic            to_hit;
  logic            shift;
  logic            sel_ok;

  // Input plus attenuated tail, clamped to node width
  always_comb begin
    sum     = {1'b0, din} +
              SW'(nodes[N-1] >> FEEDBACK_SHIFT);
    sat     = sum > SAT_MAX;
    sum_sat = sat ? {W{1'b1}} : sum[W-1:0];
  end

  assign wait_last = cnt == CW'(MEM_WAIT_CYCLES - 1);
  assign to_last   = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign done_hit  = (state == NL_WAIT) && nl.nl_done;
  assign to_hit    = (state == NL_WAIT) && !nl.nl_done
                     && to_last;
  assign shift     = done_hit || to_hit;
  assign sel_ok    = 32'(node_sel) < N;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (en) state_nxt = MEM_WAIT;
      MEM_WAIT: if (wait_last) state_nxt = NL_REQ;
      NL_REQ:   state_nxt = NL_WAIT;
      NL_WAIT:  if (shift) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Shared wait / timeout counter, cleared on every state change
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (state != state_nxt)
      cnt <= '0;
    else if (state == MEM_WAIT || state == NL_WAIT)
      cnt <= cnt + CW'(1);
  end

  // Request operand capture and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      nl_din_q    <= '0;
      sat_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state == NL_REQ) begin
        nl_din_q <= sum_sat;
        if (sat) sat_err <= 1'b1;
      end
      if (to_hit) timeout_err <= 1'b1;
    end
  end

  // Node ring: shift on completion, preload only when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) nodes[i] <= '0;
    end else if (shift) begin
      nodes[0] <= done_hit ? nl.nl_dout : '0;
      for (int i = 1; i < N; i++) nodes[i] <= nodes[i-1];
    end else if (state == IDLE && load_node && sel_ok) begin
      nodes[node_sel] <= load_node_din;
    end
  end

  // Update counter and frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (shift) begin
        if (upd_cnt == FCW'(N - 1)) begin
          upd_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          upd_cnt <= upd_cnt + FCW'(1);
        end
      end
    end
  end

  assign reservoir_valid = state == IDLE;
  assign nl.nl_start     = state == NL_REQ;
  assign nl.nl_din       = (state == NL_REQ) ? sum_sat
                                             : nl_din_q;
  assign dout            = DATA_WIDTH'(nodes[N-1]);
  assign node_dout       = sel_ok ? nodes[node_sel] : '0;

endmodule

// File: tb/tb_reservoir_core_param.sv
// Bench for reservoir_core_param: directed tables,
// corner sequences and random updates against a ring model.
module tb_reservoir_core_param;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] din;
  logic [31:0] dout;
  logic        rv;
  logic        load_node;
  logic [11:0] load_node_din;
  logic [1:0]  node_sel;
  logic [11:0] node_dout;
  logic        fd;
  logic        se;
  logic        te;

  logic        en5 = 1'b0;
  logic [31:0] din5 = '0;
  logic [31:0] dout5;
  logic        rv5;
  logic        load5;
  logic [11:0] lnd5;
  logic [2:0]  sel5;
  logic [11:0] nd5;
  logic        fd5;
  logic        se5;
  logic        te5;

  reservoir_core_param_if #(.W(12)) nl_if ();
  reservoir_core_param_if #(.W(12)) nl5 ();

  always #5 clk = ~clk;

  reservoir_core_param #(
    .NUM_VIRTUAL_NODES(4), .NODE_DATA_WIDTH(12),
    .DATA_WIDTH(32), .FEEDBACK_SHIFT(2),
    .MEM_WAIT_CYCLES(2), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .dout(dout), .reservoir_valid(rv),
    .load_node(load_node), .load_node_din(load_node_din),
    .node_sel(node_sel), .node_dout(node_dout),
    .nl(nl_if), .frame_done(fd), .sat_err(se),
    .timeout_err(te)
  );

  reservoir_core_param #(
    .NUM_VIRTUAL_NODES(5), .NODE_DATA_WIDTH(12),
    .DATA_WIDTH(32), .FEEDBACK_SHIFT(2),
    .MEM_WAIT_CYCLES(2), .TIMEOUT_CYCLES(T)
  ) dut5 (
    .clk(clk), .rst(rst), .en(en5), .din(din5),
    .dout(dout5), .reservoir_valid(rv5),
    .load_node(load5), .load_node_din(lnd5),
    .node_sel(sel5), .node_dout(nd5),
    .nl(nl5), .frame_done(fd5), .sat_err(se5),
    .timeout_err(te5)
  );

  int vec_cnt = 0;
  int miss    = 0;

  logic [11:0] m [4];
  int          m_cnt;
  bit          m_sat;
  bit          m_to;

  typedef struct {
    int          sel;
    logic [11:0] val;
  } ld_t;

  typedef struct {
    bit          pre;
    logic [11:0] pre_val;
    logic [31:0] d;
    int          dly;
    logic [11:0] r;
    logic [11:0] exp_nl;
    logic [11:0] exp_dout;
  } up_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = '0;
    m_cnt = 0;
    m_sat = 0;
    m_to  = 0;
  endtask

  task automatic chk_nodes(input string tag);
    for (int i = 0; i < 4; i++) begin
      node_sel = 2'(i);
      #1;
      chk($sformatf("%s_node%0d", tag, i),
          32'(node_dout), 32'(m[i]));
    end
  endtask

  task automatic do_load(input int sel,
                         input logic [11:0] val);
    @(negedge clk);
    load_node     = 1'b1;
    node_sel      = 2'(sel);
    load_node_din = val;
    @(negedge clk);
    load_node = 1'b0;
    m[sel]    = val;
  endtask

  task automatic noise();
    en               = 1'($urandom);
    nl_if.nl_done    = 1'($urandom);
    nl_if.nl_dout    = 12'($urandom);
    load_node        = 1'($urandom);
    node_sel         = 2'($urandom);
    load_node_din    = 12'($urandom);
  endtask

  task automatic do_update(input logic [31:0] d,
                           input int dly,
                           input logic [11:0] r,
                           input bit noisy,
                           input bit ld,
                           input int lsel,
                           input logic [11:0] lval,
                           output logic [11:0] seen);
    logic [32:0] sum;
    logic [11:0] e;
    if (ld) m[lsel] = lval;
    sum = {1'b0, d} + 33'(m[3] / 4);
    e   = (sum > 33'd4095) ? 12'hFFF : sum[11:0];
    if (sum > 33'd4095) m_sat = 1;

    @(negedge clk);
    en            = 1'b1;
    din           = d;
    load_node     = ld;
    node_sel      = 2'(lsel);
    load_node_din = lval;
    @(negedge clk);
    en        = 1'b0;
    load_node = 1'b0;
    if (noisy) noise();
    chk("busy_after_en", 32'(rv), 0);
    chk("frame_low", 32'(fd), 0);
    chk("start_early1", 32'(nl_if.nl_start), 0);
    @(negedge clk);
    if (noisy) noise();
    chk("start_early2", 32'(nl_if.nl_start), 0);
    @(negedge clk);
    nl_if.nl_done = 1'b0;
    load_node     = 1'b0;
    chk("nl_start", 32'(nl_if.nl_start), 1);
    chk("nl_din", 32'(nl_if.nl_din), 32'(e));
    seen = nl_if.nl_din;
    if (dly < T) begin
      repeat (dly + 1) @(negedge clk);
      chk("wait_busy", 32'(rv), 0);
      chk("start_once", 32'(nl_if.nl_start), 0);
      chk("nl_din_hold", 32'(nl_if.nl_din), 32'(e));
      nl_if.nl_done = 1'b1;
      nl_if.nl_dout = r;
      @(negedge clk);
      nl_if.nl_done = 1'b0;
      for (int i = 3; i > 0; i--) m[i] = m[i-1];
      m[0] = r;
    end else begin
      repeat (T) @(negedge clk);
      chk("pre_timeout_busy", 32'(rv), 0);
      chk("nl_din_hold_to", 32'(nl_if.nl_din), 32'(e));
      @(negedge clk);
      for (int i = 3; i > 0; i--) m[i] = m[i-1];
      m[0] = '0;
      m_to = 1;
    end
    en    = 1'b0;
    m_cnt = (m_cnt + 1) % 4;
    chk("valid_back", 32'(rv), 1);
    chk("frame_done", 32'(fd), 32'(m_cnt == 0));
    chk("sat_err", 32'(se), 32'(m_sat));
    chk("timeout_err", 32'(te), 32'(m_to));
    chk("dout", dout, 32'(m[3]));
    chk_nodes("upd");
  endtask

  initial begin
    ld_t ltab [4];
    up_t utab [4];
    logic [11:0] seen;
    bit          ld;
    int          kind;
    logic [31:0] d;

    ltab = '{'{0, 12'd1}, '{1, 12'd2},
             '{2, 12'd3}, '{3, 12'd400}};
    utab = '{
      '{0, 12'h000, 32'd100,  0,  12'h123, 12'd200, 12'd3},
      '{1, 12'hFFF, 32'd4000, 1,  12'h005, 12'hFFF, 12'd2},
      '{0, 12'h000, 32'd0,    15, 12'h007, 12'd0,   12'd1},
      '{0, 12'h000, 32'd1,    16, 12'h0AA, 12'd1,   12'h123}
    };

    rst = 1'b1; en = 1'b0; din = '0;
    load_node = 1'b0; load_node_din = '0; node_sel = '0;
    load5 = 1'b0; lnd5 = '0; sel5 = '0;
    nl_if.nl_done = 1'b0; nl_if.nl_dout = '0;
    nl5.nl_done = 1'b0; nl5.nl_dout = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_valid", 32'(rv), 1);
    chk("rst_start", 32'(nl_if.nl_start), 0);
    chk("rst_nl_din", 32'(nl_if.nl_din), 0);
    chk("rst_sat", 32'(se), 0);
    chk("rst_to", 32'(te), 0);
    chk("rst_frame", 32'(fd), 0);
    chk_nodes("rst");

    foreach (ltab[i]) do_load(ltab[i].sel, ltab[i].val);
    chk_nodes("load");

    @(negedge clk);
    load5 = 1'b1; sel5 = 3'd4; lnd5 = 12'hABC;
    @(negedge clk);
    sel5 = 3'd5; lnd5 = 12'h111;
    @(negedge clk);
    load5 = 1'b0;
    sel5 = 3'd4; #1 chk("oor_sel4", 32'(nd5), 32'hABC);
    sel5 = 3'd5; #1 chk("oor_sel5", 32'(nd5), 0);
    sel5 = 3'd7; #1 chk("oor_sel7", 32'(nd5), 0);
    sel5 = 3'd0; #1 chk("oor_sel0", 32'(nd5), 0);

    foreach (utab[i]) begin
      if (utab[i].pre) do_load(3, utab[i].pre_val);
      do_update(utab[i].d, utab[i].dly, utab[i].r,
                1'b0, 1'b0, 0, 12'h0, seen);
      chk($sformatf("tab%0d_nl_din", i),
          32'(seen), 32'(utab[i].exp_nl));
      chk($sformatf("tab%0d_dout", i),
          dout, 32'(utab[i].exp_dout));
    end

    @(negedge clk);
    nl_if.nl_done = 1'b1;
    nl_if.nl_dout = 12'h555;
    @(negedge clk);
    nl_if.nl_done = 1'b0;
    chk("late_done_valid", 32'(rv), 1);
    chk("frame_single", 32'(fd), 0);
    chk_nodes("late_done");

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       d = $urandom_range(0, 300);
        1:       d = $urandom_range(3000, 4095);
        2:       d = $urandom;
        default: d = $urandom_range(0, 4095);
      endcase
      ld = ($urandom_range(0, 3) == 0);
      do_update(d, int'($urandom_range(0, T + 1)),
                12'($urandom), 1'b1, ld,
                int'($urandom_range(0, 3)),
                12'($urandom), seen);
    end

    @(negedge clk);
    en = 1'b1; din = 32'd5;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("in_nl_wait", 32'(rv), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("abort_valid", 32'(rv), 1);
    chk("abort_start", 32'(nl_if.nl_start), 0);
    chk("abort_sat", 32'(se), 0);
    chk("abort_to", 32'(te), 0);
    chk_nodes("abort");
    nl_if.nl_done = 1'b1;
    nl_if.nl_dout = 12'h321;
    @(negedge clk);
    nl_if.nl_done = 1'b0;
    chk("abort_late_valid", 32'(rv), 1);
    chk_nodes("abort_late");

    do_update(32'd77, 3, 12'h0F0, 1'b0, 1'b0, 0,
              12'h0, seen);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, miss);
    $finish;
  end

endmodule
